// File: rtl/seq_alu.sv
// seq_alu: registered ALU with flags, one op per start, done pulse.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add MUL path.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             sign_flag,
  output logic             overflow_flag,
  output logic             illegal
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;
  logic   accept, is_mul, last;

  logic [WIDTH-1:0] res_c;
  logic             c_c, v_c, ill_c;
  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   sum, sl, sr;
  logic signed [WIDTH:0] sa;

`ifdef SEQ_ALU_MUL_EN
  logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [SHW:0]       cnt_q;

  assign is_mul = opcode == 4'b1010;
  assign last   = cnt_q == (SHW+1)'(1);
  assign acc_d  = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign busy   = state_q == MUL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (accept && is_mul) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
      cnt_q    <= (SHW+1)'(WIDTH);
    end else if (state_q == MUL) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - 1'b1;
    end
  end
`else
  assign is_mul = 1'b0;
  assign last   = 1'b0;
  assign busy   = 1'b0;
`endif

  assign done = state_q == DONE;

  // Shifts carry one extra bit so the last bit shifted out lands at a fixed index.
  always_comb begin
    sh    = b[SHW-1:0];
    sum   = {1'b0, a} + {1'b0, b};
    sl    = {1'b0, a} << sh;
    sr    = {a, 1'b0} >> sh;
    sa    = $signed({a, 1'b0}) >>> sh;
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    ill_c = 1'b0;
    unique case (opcode)
      4'b0000: begin
        res_c = sum[WIDTH-1:0];
        c_c   = sum[WIDTH];
        v_c   = (a[WIDTH-1] == b[WIDTH-1]) &&
                (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0001: begin
        res_c = a - b;
        c_c   = a < b;
        v_c   = (a[WIDTH-1] != b[WIDTH-1]) &&
                (res_c[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0010: res_c = a & b;
      4'b0011: res_c = a | b;
      4'b0100: res_c = a ^ b;
      4'b0101: res_c = ~a;
      4'b0110: begin
        res_c = sl[WIDTH-1:0];
        c_c   = sl[WIDTH];
      end
      4'b0111: begin
        res_c = sr[WIDTH:1];
        c_c   = sr[0];
      end
      4'b1000: begin
        res_c = sa[WIDTH:1];
        c_c   = sa[0];
      end
      4'b1001: begin
        res_c = '0 - b;
        c_c   = |b;
        v_c   = b == MIN_NEG;
      end
      default: ill_c = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      MUL: if (last) state_d = DONE;
      default: begin
        accept  = start;
        if (start) state_d = is_mul ? MUL : DONE;
        else       state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result        <= '0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      sign_flag     <= 1'b0;
      overflow_flag <= 1'b0;
      illegal       <= 1'b0;
    end else if (accept && !is_mul) begin
      result        <= res_c;
      zero_flag     <= res_c == '0;
      carry_flag    <= c_c;
      sign_flag     <= res_c[WIDTH-1];
      overflow_flag <= v_c;
      illegal       <= ill_c;
    end
`ifdef SEQ_ALU_MUL_EN
    else if (state_q == MUL && last) begin
      result        <= acc_d[WIDTH-1:0];
      zero_flag     <= acc_d[WIDTH-1:0] == '0;
      carry_flag    <= |acc_d[2*WIDTH-1:WIDTH];
      sign_flag     <= acc_d[WIDTH-1];
      overflow_flag <= |acc_d[2*WIDTH-1:WIDTH];
      illegal       <= 1'b0;
    end
`endif
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered successor to the KGP_RISC combinational `alu`. It accepts one operation per `start` pulse and returns a registered `result` with zero, carry, sign and overflow flags plus a one-cycle `done` pulse. Width is configurable, and an optional iterative shift-add multiplier can be compiled in. It sits between the register-file read stage and write-back, and the control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand/result width; power of two, 8..64.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width (derived; do not override).

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `busy`=0.
- `opcode` in 4: operation select.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B; shift amount = `b[SHW-1:0]`.
- `busy` out 1: multiply in progress; `start` ignored.
- `done` out 1: one-cycle pulse; `result` and flags valid from this cycle.
- `result` out WIDTH: registered result; holds until next completion.
- `zero_flag`, `carry_flag`, `sign_flag`, `overflow_flag` out 1 each: registered flags.
- `illegal` out 1: registered; set on completion of an undefined opcode.

## Operation
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 NOT (~a)
  - 0110 SLL
  - 0111 SRL
  - 1000 SRA
  - 1001 NEG (-b)
  - 1010 MUL (low WIDTH bits, unsigned)
  - 1011–1111 illegal
- Flags:
  - `zero` = (result==0).
  - `sign` = result[WIDTH-1].
  - ADD: `carry` = carry-out; `overflow` = signed overflow.
  - SUB/NEG: `carry` = borrow (a<b unsigned; NEG: b≠0); `overflow` = signed overflow (NEG: b = most-negative value).
  - Shifts: `carry` = last bit shifted out, 0 if amount 0; `overflow`=0.
  - Logic ops: `carry`=`overflow`=0.
  - MUL: `carry`=`overflow`= upper WIDTH bits of the full product nonzero.
- Illegal opcode: `result`=0, `zero`=1, other flags 0, `illegal`=1. For legal ops `illegal`=0.
- FSM:
  - IDLE: on `start` with a single-cycle op, compute and register, then go to DONE. On `start` with MUL, latch a and b, clear the accumulator, set counter=WIDTH, then go to MUL.
  - MUL: each cycle add the shifted multiplicand if the multiplier LSB is 1, shift, and decrement the counter. When the counter reaches 0, register the result and flags, then go to DONE.
  - DONE: `done`=1. A `start` is accepted exactly as in IDLE, which allows back-to-back operation. Otherwise go to IDLE.
- `busy` = (state==MUL).
- Operands and opcode are sampled only on the accepting edge; later input changes have no effect.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, `busy`=0, `done`=0, `result`=0.
  - All flags=0, `illegal`=0.
  - Reset during MUL aborts the operation; no `done` is issued.
- Single-cycle ops: `start` accepted at edge N; `done`, `result` and flags valid during cycle N+1. Throughput is one op per cycle.
- MUL: accepted at edge N; `busy`=1 for cycles N+1..N+WIDTH; `done` in cycle N+WIDTH+1. A `start` during `busy` is dropped with no queueing.
- Outputs change only on `done` edges or reset.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL datapath and MUL state are present, with behaviour as above.
- `SEQ_ALU_MUL_EN` undefined: no multiplier logic and `busy` is tied 0. Opcode 1010 is treated as illegal, completing in 1 cycle with `illegal`=1 and `result`=0.

## Test plan
- Reset: assert `rst_n`=0 mid-MUL (WIDTH=32). Required: all outputs 0 immediately, no `done` afterwards, and the next ADD works normally.
- ADD 10+20 = 30, flags 0. ADD 0x7FFFFFFF+0x7FFFFFFF = 0xFFFFFFFE, `overflow`=1, `sign`=1, `carry`=0. ADD 0xFFFFFFFF+1 = 0, `zero`=1, `carry`=1.
- SUB 7-(-1) = 8, `carry`=1, `overflow`=0. SUB 5-5 = 0, `zero`=1. NEG b=0x80000000 = 0x80000000, `overflow`=1.
- Shifts: SLL 0x80000001 by 1 = 0x00000002, `carry`=1. SRA 0xFFFFFF00 by 4 = 0xFFFFFFF0. SRL by 0 = unchanged, `carry`=0.
- MUL 0x00A11A78×3 = 0x01E34F68, `done` exactly 33 cycles after accept. MUL 0x10000×0x10000 = 0, `carry`=`overflow`=1. A `start` during `busy` is ignored.
- Back-to-back: ADD, XOR and opcode 1111 in consecutive cycles. Required: three `done` pulses on consecutive cycles; the third has `illegal`=1 and `result`=0. Without `SEQ_ALU_MUL_EN`, opcode 1010 gives `illegal`=1.
